// File: rtl/interp_upsampler_pkg.sv
// Shared audio constants and types for the playback-side upsampler.
// OUT_SPACING_48K is the clk_m cycle count per 48 kHz output sample.
package interp_upsampler_pkg;

    localparam int AUDIO_DATA_WIDTH = 16;
    localparam int CLK_M_HZ         = 98_300_000;
    localparam int OUT_RATE_HZ      = 48_000;

    // Rounded to the nearest whole cycle so the output rate error stays below half a cycle.
    function automatic int cycles_per_sample(input int clk_hz, input int rate_hz);
        return (clk_hz + rate_hz / 2) / rate_hz;
    endfunction

    localparam int OUT_SPACING_48K = cycles_per_sample(CLK_M_HZ, OUT_RATE_HZ);

    typedef enum logic {
        IDLE,
        EMIT
    } ups_state_t;

endpackage

// File: rtl/interp_upsampler_if.sv
// Sample-stream interface for the interpolating upsampler.
// The master side produces samples; the slave side is the upsampler.
interface interp_upsampler_if #(
    parameter int DATA_WIDTH = interp_upsampler_pkg::AUDIO_DATA_WIDTH
);

    logic                         valid_in;
    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         valid_out;
    logic signed [DATA_WIDTH-1:0] data_out;
    logic                         busy_out;
    logic                         overrun_out;

    modport master (
        output valid_in,
        output data_in,
        input  valid_out,
        input  data_out,
        input  busy_out,
        input  overrun_out
    );

    modport slave (
        input  valid_in,
        input  data_in,
        output valid_out,
        output data_out,
        output busy_out,
        output overrun_out
    );

endinterface

// File: rtl/interp_upsampler_pace_counter.sv
// Modulo-N pacing counter; tick is high while enabled and the count sits at
// zero, giving one strobe every N enabled cycles starting right after a clear.
module pace_counter #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == CW'(N - 1)) ? '0 : count + 1'b1;
        end
    end

    assign tick = enable && (count == '0);

endmodule

// File: rtl/interp_upsampler.sv
// Linear-interpolating upsampler: each input sample becomes 2^LOG2_FACTOR
// evenly paced outputs ramping from the previous sample to the new one.
module interp_upsampler
    import interp_upsampler_pkg::*;
#(
    parameter int DATA_WIDTH  = AUDIO_DATA_WIDTH,
    parameter int LOG2_FACTOR = 2,
    parameter int OUT_SPACING = OUT_SPACING_48K
) (
    input  logic               clk_in,
    input  logic               rst_in,
    interp_upsampler_if.slave  bus
);

    localparam int L   = 1 << LOG2_FACTOR;
    localparam int DW1 = DATA_WIDTH + 1;
    localparam int AW  = DATA_WIDTH + LOG2_FACTOR + 1;
    localparam int IW  = LOG2_FACTOR + 1;

    ups_state_t                   state;
    logic signed [DATA_WIDTH-1:0] prev;
    logic signed [DATA_WIDTH-1:0] cur_x;
    logic signed [DATA_WIDTH-1:0] pend;
    logic                         pend_full;
    logic signed [DW1-1:0]        delta;
    logic signed [AW-1:0]         acc;
    logic [IW-1:0]                emit_idx;
    logic                         drop_q;

    logic                         accept;
    logic                         tick;
    logic                         last;
    logic signed [DATA_WIDTH-1:0] start_base;
    logic signed [DATA_WIDTH-1:0] start_x;
    logic signed [DW1-1:0]        start_delta;
    logic signed [AW-1:0]         start_acc;
    logic signed [AW-1:0]         delta_ext;
    logic signed [AW-1:0]         sum;
    logic signed [DATA_WIDTH-1:0] emit_val;

    assign accept = (state == IDLE) && bus.valid_in;

    pace_counter #(
        .N (OUT_SPACING)
    ) u_pace (
        .clk    (clk_in),
        .rst    (rst_in),
        .clear  (accept),
        .enable (state == EMIT),
        .tick   (tick)
    );

    assign last = tick && (emit_idx == IW'(L - 1));

    // A chained block ramps from the sample just reached; a fresh one from prev.
    always_comb begin
        start_base  = (state == IDLE) ? prev : cur_x;
        start_x     = pend_full ? pend : bus.data_in;
        start_delta = {start_x[DATA_WIDTH-1], start_x} - {start_base[DATA_WIDTH-1], start_base};
        start_acc   = {{(LOG2_FACTOR + 1){start_base[DATA_WIDTH-1]}}, start_base} <<< LOG2_FACTOR;
    end

    assign delta_ext = {{(AW - DW1){delta[DW1-1]}}, delta};
    assign sum       = acc + delta_ext;
    assign emit_val  = sum[DATA_WIDTH+LOG2_FACTOR-1:LOG2_FACTOR];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            prev            <= '0;
            cur_x           <= '0;
            pend            <= '0;
            pend_full       <= 1'b0;
            delta           <= '0;
            acc             <= '0;
            emit_idx        <= '0;
            drop_q          <= 1'b0;
            bus.valid_out   <= 1'b0;
            bus.data_out    <= '0;
            bus.busy_out    <= 1'b0;
            bus.overrun_out <= 1'b0;
        end else begin
            bus.valid_out   <= 1'b0;
            bus.overrun_out <= drop_q;
            bus.busy_out    <= (state == EMIT) && pend_full;
            drop_q          <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.valid_in) begin
                        state    <= EMIT;
                        cur_x    <= bus.data_in;
                        delta    <= start_delta;
                        acc      <= start_acc;
                        emit_idx <= '0;
                    end
                end

                EMIT: begin
                    if (tick) begin
                        bus.valid_out <= 1'b1;
                        bus.data_out  <= emit_val;
                        acc           <= sum;
                        emit_idx      <= emit_idx + 1'b1;
                    end
                    // An input on the final emission either chains straight in or is dropped.
                    if (last) begin
                        prev     <= cur_x;
                        emit_idx <= '0;
                        if (pend_full || bus.valid_in) begin
                            cur_x     <= start_x;
                            delta     <= start_delta;
                            acc       <= start_acc;
                            pend_full <= 1'b0;
                            drop_q    <= pend_full && bus.valid_in;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (bus.valid_in) begin
                        if (pend_full) begin
                            drop_q <= 1'b1;
                        end else begin
                            pend      <= bus.data_in;
                            pend_full <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
